// File: rtl/approx_div16by8_seq.sv
// approx_div16by8_seq
//   Sequential unsigned 16/8 restoring divider producing an 8-bit quotient
//   and a zero-extended remainder. APPROX_BITS low quotient iterations are
//   skipped (those quotient bits read 0), shortening latency to 8-APPROX_BITS
//   cycles. Divide-by-zero and quotient overflow finish in the cycle right
//   after the operands are accepted.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   operand handshake (dividend[15:0], divisor[7:0])
//   out_valid/ready  result handshake (q[7:0], r[15:0], div_by_zero, ovf)
module approx_div16by8_seq #(
    parameter int unsigned APPROX_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  q,
    output logic [15:0] r,
    output logic        div_by_zero,
    output logic        ovf
);

    // Index of the final quotient bit that is actually computed.
    localparam logic [2:0]  LAST_IDX = 3'(APPROX_BITS);
    // Dividend bits below the computed quotient pass straight into r.
    localparam logic [15:0] LOW_MASK = 16'((32'd1 << APPROX_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    // Partial remainder: always < divisor after a step, so 8 bits hold it.
    logic [7:0]  p_q, p_d;
    logic [2:0]  i_q, i_d;
    logic [7:0]  q_q, q_d;
    logic [15:0] r_q, r_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [8:0]  t;
    logic        take;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        p_d         = p_q;
        i_d         = i_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        t    = {p_q, dvd_q[i_q]};
        take = (t >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    in_ready_d = 1'b0;
                    if (divisor == 8'd0) begin
                        dz_d        = 1'b1;
                        ovf_d       = 1'b0;
                        q_d         = 8'hFF;
                        r_d         = dividend;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (dividend[15:8] >= divisor) begin
                        // Quotient would need a 9th bit.
                        dz_d        = 1'b0;
                        ovf_d       = 1'b1;
                        q_d         = 8'hFF;
                        r_d         = dividend;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                        p_d     = dividend[15:8];
                        q_d     = 8'h00;
                        i_d     = 3'd7;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // t < divisor <= 255 when not taken, so t[8] is 0 there.
                p_d = take ? 8'(t - {1'b0, dvs_q}) : t[7:0];
                if (take) q_d[i_q] = 1'b1;
                i_d = i_q - 3'd1;
                if (i_q == LAST_IDX) begin
                    r_d         = ({8'h00, p_d} << APPROX_BITS) | (dvd_q & LOW_MASK);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= 16'h0000;
            dvs_q       <= 8'h00;
            p_q         <= 8'h00;
            i_q         <= 3'd0;
            q_q         <= 8'h00;
            r_q         <= 16'h0000;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            p_q         <= p_d;
            i_q         <= i_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dz_q;
    assign ovf         = ovf_q;

endmodule

// File: doc/approx_div16by8_seq.md
Name: approx_div16by8_seq

Overview:
- Sequential unsigned 16-by-8 divider. It is the inverse-direction companion to the team's approximate 8x8 unsigned multipliers: a product-width dividend and an 8-bit divisor produce an 8-bit quotient and a remainder.
- It computes one quotient bit per cycle with a restoring algorithm. APPROX_BITS skips the low-order quotient iterations, trading accuracy for latency.
- It sits behind valid/ready handshakes in the error-evaluation and inverse-datapath benches.

Parameters:
- APPROX_BITS, default 0, legal range 0..7. Number of low quotient bits not computed; they are forced to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands.
- dividend  in  16  unsigned dividend.
- divisor  in  8  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- q  out  8  quotient.
- r  out  16  remainder, zero-extended.
- div_by_zero  out  1  divisor was 0.
- ovf  out  1  quotient does not fit in 8 bits.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, at a clk edge with rst=1: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0, ovf=0. Reset overrides any in-flight operation; no result for the aborted operation is ever presented.
- Let K=APPROX_BITS and N=8-K.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch dividend and divisor.
  - If divisor==0: div_by_zero=1, ovf=0, q=8'hFF, r=dividend, go to DONE.
  - Else if dividend[15:8] >= divisor: ovf=1, div_by_zero=0, q=8'hFF, r=dividend, go to DONE.
  - Else: P=dividend[15:8] (9-bit register), q=0, clear both flags, bit index i=7, go to CALC.
- State CALC (in_ready=0, out_valid=0), once per cycle:
  - T={P[7:0], dividend[i]} (9 bits).
  - If T>=divisor then q[i]=1 and P=T-divisor, else P=T.
  - i decrements.
  - After the step for i==K, go to DONE.
  - Exactly N cycles are spent in CALC.
- State DONE:
  - out_valid=1, in_ready=0.
  - For a normal divide, r = {P[7:0], dividend[K-1:0]} zero-extended to 16 bits. When K=0, r=P[7:0].
  - Invariant for every normal result: r == dividend - q*divisor. When K=0, additionally r < divisor.
  - q, r and the flags hold stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
- Latency, measured from the accepting edge to the first cycle with out_valid=1:
  - Normal divide: N cycles.
  - Zero or overflow case: 1 cycle.
- Throughput:
  - The next operand is accepted no earlier than the cycle after the output handshake.
  - in_ready is never high in the same cycle as out_valid, so there is no simultaneous accept.
- Approximation:
  - q[K-1:0] is always 0.
  - The quotient error is less than 2^K. Its sign is never positive (floor truncation).
- Operand changes on the dividend and divisor inputs after acceptance have no effect.

Test Plan:
- K=0, dividend=1000, divisor=7 -> q=142, r=6, both flags 0. out_valid rises exactly 8 cycles after the accept.
- K=3, dividend=1000, divisor=7 -> q=136, r=48, both flags 0. out_valid rises 5 cycles after the accept.
- K=0 max legal case, dividend=16'hFEFF, divisor=255 -> q=255, r=254. Also dividend=16'hFFFF, divisor=255 -> ovf=1, q=8'hFF, r=16'hFFFF, out_valid after 1 cycle.
- dividend=16'h1234, divisor=0 -> div_by_zero=1, ovf=0, q=8'hFF, r=16'h1234. Also dividend=16'h0800, divisor=8 -> ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q, r and flags stable and in_ready=0 throughout. Changing the dividend input meanwhile has no effect. After the handshake, in_ready=1 the next cycle.
- Reset mid-CALC: assert rst in CALC step 3 -> next cycle IDLE, in_ready=1, out_valid=0, outputs 0. A subsequent 1000/7 returns q=142, r=6.
- Random sweep of 10k pairs per K in {0,3,7} -> r == dividend-q*divisor. For K=0 also q == floor(dividend/divisor) whenever no flag is set.
